// File: rtl/parallel_in_parallel_out_pipo_8_bit_if.sv
// Data bus of the PIPO holding register: the word to capture and its registered copy.
interface parallel_in_parallel_out_pipo_8_bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Parallel_Data_In;
    logic [WIDTH-1:0] Parallel_Data_Out;

    modport master (
        output Parallel_Data_In,
        input  Parallel_Data_Out
    );

    modport slave (
        input  Parallel_Data_In,
        output Parallel_Data_Out
    );
endinterface

// File: rtl/parallel_in_parallel_out_pipo_8_bit.sv
// One-cycle parallel-in/parallel-out holding register: captures the whole word on
// every rising edge and clears asynchronously while reset is high.
module parallel_in_parallel_out_pipo_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic                                   Clk_In,
    input  logic                                   Reset_In,
    parallel_in_parallel_out_pipo_8_bit_if.slave   pipo_bus
);

    logic [WIDTH-1:0] data_q;

    // Reset dominates any edge, so an edge seen while Reset_In is high never loads.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q <= '0;
        end else begin
            data_q <= pipo_bus.Parallel_Data_In;
        end
    end

    assign pipo_bus.Parallel_Data_Out = data_q;

endmodule

// File: tb/tb_parallel_in_parallel_out_pipo_8_bit.sv
// Scoreboard bench for the PIPO register: stimulus queues expected words, a monitor
// pops and compares after each rising edge or on an explicit between-edge check.
module tb_parallel_in_parallel_out_pipo_8_bit;

    logic clk;
    logic rst;

    int   n_vectors = 0;
    int   n_fail    = 0;

    logic [7:0] exp_q[$];
    event       check_ev;

    logic [7:0] stream_words [10] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55,
                                     8'hAA, 8'h7E, 8'hE7, 8'h0F, 8'hF0};

    parallel_in_parallel_out_pipo_8_bit_if #(.WIDTH(8)) pipo_bus ();

    parallel_in_parallel_out_pipo_8_bit #(.WIDTH(8)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .pipo_bus (pipo_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a word now, expect it right after the coming rising edge.
    task automatic loadAfterNextEdge(input logic [7:0] data);
        pipo_bus.Parallel_Data_In = data;
        exp_q.push_back(data);
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [7:0] expected);
        @(negedge clk);
        pipo_bus.Parallel_Data_In = data;
        exp_q.push_back(expected);
        @(posedge clk);
        #2;
    endtask

    // Between-edge check of the current output value.
    task automatic checkOutput(input logic [7:0] expected);
        exp_q.push_back(expected);
        -> check_ev;
        #2;
    endtask

    initial begin : monitor
        logic [7:0] expected;
        forever begin
            @(posedge clk or check_ev);
            #1;
            if (exp_q.size() > 0) begin
                expected = exp_q.pop_front();
                n_vectors++;
                if (pipo_bus.Parallel_Data_Out !== expected) begin
                    n_fail++;
                    $display("[TB] FAIL vector %0d at %0t: Parallel_Data_Out=%h required=%h",
                             n_vectors, $time, pipo_bus.Parallel_Data_Out, expected);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        pipo_bus.Parallel_Data_In = 8'hFF;
        #2;
        checkOutput(8'h00);

        // Reset held across two edges with all-ones on the input.
        applyStimulus(8'hFF, 8'h00);
        applyStimulus(8'hFF, 8'h00);

        // Release on a falling edge: nothing loads until the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        pipo_bus.Parallel_Data_In = 8'h81;
        #1;
        checkOutput(8'h00);
        loadAfterNextEdge(8'h81);

        applyStimulus(8'hA5, 8'hA5);
        applyStimulus(8'h3C, 8'h3C);

        // Input change between edges must not reach the output.
        applyStimulus(8'h12, 8'h12);
        pipo_bus.Parallel_Data_In = 8'h34;
        checkOutput(8'h12);
        #2;
        checkOutput(8'h12);
        applyStimulus(8'h34, 8'h34);

        // Asynchronous clear mid-cycle, then resume.
        applyStimulus(8'hC3, 8'hC3);
        #1;
        rst = 1'b1;
        checkOutput(8'h00);
        #1;
        rst = 1'b0;
        loadAfterNextEdge(8'h5A);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(stream_words[k], stream_words[k]);
        end
        pipo_bus.Parallel_Data_In = 8'h99;
        checkOutput(stream_words[9]);

        // Reset asserted coincident with a rising edge: no load of the new word.
        @(posedge clk);
        rst = 1'b1;
        pipo_bus.Parallel_Data_In = 8'h77;
        #2;
        checkOutput(8'h00);
        applyStimulus(8'h66, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        loadAfterNextEdge(8'h66);

        #20;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule
